spectrum_band_meter: RTL and testbench

Parametrised spectrum level meter that replaces the fixed 10 Hz acquisition strobe and the single-byte LED capture in the top level. It generates the periodic acquisition strobe for the FFT block and consumes the frequency-sample write stream (valid/address/data) that also feeds the image controller. It folds FFT bins into N_BANDS bands and keeps a per-band peak, with live or peak-hold-with-decay display. It publishes all band levels plus a 16-LED thermometer of one selected band.

---
 rtl/spectrum_band_meter.sv | 148 ++++++++++++++
 tb/tb_spectrum_band_meter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spectrum_band_meter.sv
// spectrum_band_meter: acquisition strobe, per-band peak fold, live/peak-hold display and LED thermometer
module spectrum_band_meter #(
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 10,
   parameter int N_BANDS       = 16,
   parameter int BINS_PER_BAND = 32,
   parameter int PRESC         = 2500000,
   parameter int HOLD_FRAMES   = 5,
   parameter int DECAY_STEP    = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sample_valid,
   input  logic [ADDR_W-1:0]            sample_addr,
   input  logic [DATA_W-1:0]            sample_data,
   input  logic                         mode,
   input  logic [$clog2(N_BANDS)-1:0]   band_sel,
   output logic                         frame_start,
   output logic [N_BANDS*DATA_W-1:0]    level_out,
   output logic                         levels_valid,
   output logic [15:0]                  led_bar
);
   localparam int BW = $clog2(N_BANDS);
   localparam int BB = $clog2(BINS_PER_BAND);
   localparam int CW = (PRESC < 2) ? 1 : $clog2(PRESC);
   localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [DATA_W-1:0] STEP      = DATA_W'(DECAY_STEP);
   localparam logic [HW-1:0]     HOLD_INIT = HW'(HOLD_FRAMES);
   localparam logic [ADDR_W:0]   N_BINS    = (ADDR_W+1)'(N_BANDS * BINS_PER_BAND);
   localparam logic [CW-1:0]     CNT_LAST  = CW'(PRESC - 1);
   localparam logic [BW-1:0]     IDX_LAST  = BW'(N_BANDS - 1);

   typedef enum logic [1:0] {COLLECT, UPDATE, LATCH} state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic                frame_start_q;
   logic                levels_valid_q;
   logic [BW-1:0]       idx_q;
   logic [DATA_W-1:0]   acc_q  [N_BANDS];
   logic [DATA_W-1:0]   acc_d  [N_BANDS];
   logic [DATA_W-1:0]   disp_q [N_BANDS];
   logic [HW-1:0]       hold_q [N_BANDS];
   logic [15:0]         led_q;
   logic [15:0]         led_d;
   logic [N_BANDS-1:0]  hit;
   logic [N_BANDS-1:0]  clr;
   logic                in_range;
   logic [BW-1:0]       s_band;
   logic [DATA_W-1:0]   cur_acc;
   logic [DATA_W-1:0]   cur_disp;
   logic [HW-1:0]       cur_hold;
   logic [DATA_W-1:0]   disp_d;
   logic [HW-1:0]       hold_d;
   logic [3:0]          led_v;
   logic                grow;

   assign in_range = {1'b0, sample_addr} < N_BINS;
   assign s_band   = sample_addr[BB +: BW];

   assign cur_acc  = acc_q[idx_q];
   assign cur_disp = disp_q[idx_q];
   assign cur_hold = hold_q[idx_q];
   assign grow     = cur_acc > cur_disp;

   // next display value and hold count for the band being updated this cycle
   always_comb begin
      disp_d = !mode ? cur_acc : grow ? cur_acc : (cur_hold != '0) ? cur_disp : (cur_disp > STEP) ? cur_disp - STEP : '0;
      hold_d = !mode ? '0 : grow ? HOLD_INIT : (cur_hold != '0) ? cur_hold - HW'(1) : '0;
   end

   // per-band running max; a band cleared this cycle restarts from the colliding sample
   always_comb begin
      for (int b = 0; b < N_BANDS; b++) begin
         hit[b]   = sample_valid && in_range && (s_band == BW'(b));
         clr[b]   = (state_q == UPDATE) && (idx_q == BW'(b));
         acc_d[b] = clr[b] ? (hit[b] ? sample_data : '0) : (hit[b] && sample_data > acc_q[b]) ? sample_data : acc_q[b];
      end
   end

   // accumulator registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < N_BANDS; b++) acc_q[b] <= '0;
      end else begin
         for (int b = 0; b < N_BANDS; b++) acc_q[b] <= acc_d[b];
      end
   end

   // prescaler: frame_start is registered, one cycle per counter wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
         frame_start_q <= (cnt_q == CNT_LAST);
      end
   end

   // frame FSM: walk every band once per frame, then pulse levels_valid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= COLLECT;
         idx_q          <= '0;
         levels_valid_q <= 1'b0;
         for (int b = 0; b < N_BANDS; b++) begin
            disp_q[b] <= '0;
            hold_q[b] <= '0;
         end
      end else begin
         levels_valid_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               idx_q <= '0;
               if (frame_start_q) state_q <= UPDATE;
            end
            UPDATE: begin
               disp_q[idx_q] <= disp_d;
               hold_q[idx_q] <= hold_d;
               idx_q         <= idx_q + BW'(1);
               if (idx_q == IDX_LAST) begin
                  state_q        <= LATCH;
                  levels_valid_q <= 1'b1;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign led_v = disp_q[band_sel][DATA_W-1 -: 4];
   assign led_d = (16'd1 << led_v) - 16'd1;

   // thermometer of the selected band, top nibble sets the number of lit LEDs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) led_q <= '0;
      else led_q <= led_d;
   end

   for (genvar g = 0; g < N_BANDS; g++) begin : g_level
      assign level_out[g*DATA_W +: DATA_W] = disp_q[g];
   end

   assign frame_start  = frame_start_q;
   assign levels_valid = levels_valid_q;
   assign led_bar      = led_q;
endmodule

// File: tb/tb_spectrum_band_meter.sv
// tb_spectrum_band_meter: scoreboard bench for spectrum_band_meter with directed vectors
module tb_spectrum_band_meter;
   localparam int P = 64;

   typedef struct {
      int          cyc;
      logic [31:0] lvl;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [9:0]  sample_addr = '0;
   logic [7:0]  sample_data = '0;
   logic        mode = 1'b0;
   logic [1:0]  band_sel = '0;
   logic        frame_start;
   logic [31:0] level_out;
   logic        levels_valid;
   logic [15:0] led_bar;

   int   checks = 0;
   int   failures = 0;
   int   edges = 0;
   int   base = 0;
   bit   run = 1'b0;
   exp_t exp_q[$];

   spectrum_band_meter #(
      .DATA_W(8), .ADDR_W(10), .N_BANDS(4), .BINS_PER_BAND(4),
      .PRESC(P), .HOLD_FRAMES(2), .DECAY_STEP(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_addr(sample_addr),
      .sample_data(sample_data), .mode(mode), .band_sel(band_sel), .frame_start(frame_start),
      .level_out(level_out), .levels_valid(levels_valid), .led_bar(led_bar)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges++;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // monitor: frame_start timing model and levels_valid scoreboard
   always @(negedge clk) begin
      int   c;
      exp_t e;
      if (run) begin
         c = edges - base;
         if (frame_start || (c > 0 && c % P == 0)) begin
            chk("frame_start", {31'd0, frame_start}, {31'd0, c > 0 && c % P == 0});
            chk("frame_start_in_collect", 32'(dut.state_q), 32'd0);
         end
         if (levels_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_levels_valid: cycle %0d level_out %h, none expected", c, level_out);
            end else begin
               e = exp_q.pop_front();
               chk("levels_valid_cycle", c, e.cyc);
               chk("level_out", level_out, e.lvl);
            end
         end
      end
   end

   task automatic wait_cyc(int c);
      while (edges - base < c) @(negedge clk);
   endtask

   task automatic put(int c, int a, int d);
      wait_cyc(c);
      sample_valid = 1'b1;
      sample_addr  = 10'(a);
      sample_data  = 8'(d);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic expect_frame(int k, logic [31:0] lvl);
      exp_q.push_back('{cyc: k * P + 5, lvl: lvl});
   endtask

   task automatic do_reset();
      chk("pending_frames", exp_q.size(), 0);
      exp_q.delete();
      run = 1'b0;
      reset_n = 1'b0;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level_out", level_out, 32'd0);
      chk("rst_levels_valid", {31'd0, levels_valid}, 32'd0);
      chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
      chk("rst_led_bar", {16'd0, led_bar}, 32'd0);
      reset_n = 1'b1;
      base = edges;
      run = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b0 [14] = '{8'hA0, 8'hA0, 8'hA0, 8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00, 8'h00};
      logic [7:0] b1 [14] = '{8'h35, 8'h35, 8'h35, 8'h25, 8'h15, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      // reset and strobe timing, empty frames
      mode = 1'b0;
      do_reset();
      for (int k = 1; k <= 3; k++) expect_frame(k, 32'h0);
      wait_cyc(200);
      // live fold of 16 bins into 4 bands
      do_reset();
      band_sel = 2'd3;
      expect_frame(1, 32'hF0B07030);
      for (int a = 0; a < 16; a++) put(10 + a, a, a * 16);
      wait_cyc(70);
      chk("led_band3", {16'd0, led_bar}, 32'h7FFF);
      band_sel = 2'd0;
      wait_cyc(72);
      chk("led_band0", {16'd0, led_bar}, 32'h0007);
      wait_cyc(75);
      // out-of-range bins are dropped
      do_reset();
      expect_frame(1, 32'h00002200);
      put(10, 16, 8'hFF);
      put(11, 5, 8'h22);
      wait_cyc(75);
      // peak hold with decay and saturation at zero
      mode = 1'b1;
      do_reset();
      for (int k = 1; k <= 14; k++) expect_frame(k, {16'h0, b1[k-1], b0[k-1]});
      put(10, 0, 8'hA0);
      put(11, 4, 8'h35);
      wait_cyc(14 * P + 10);
      // samples around the update sweep, including the band1 clear cycle
      mode = 1'b0;
      do_reset();
      expect_frame(1, 32'h33001100);
      expect_frame(2, 32'h00004044);
      put(10, 5, 8'h11);
      put(P + 1, 12, 8'h33);
      put(P + 2, 4, 8'h40);
      put(P + 3, 0, 8'h44);
      wait_cyc(2 * P + 10);
      // reset in the middle of an update sweep
      do_reset();
      expect_frame(1, 32'h00770000);
      put(10, 8, 8'h77);
      put(100, 8, 8'h55);
      wait_cyc(2 * P + 2);
      do_reset();
      expect_frame(1, 32'h0);
      wait_cyc(P + 10);
      chk("final_pending_frames", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
